// File: rtl/seq_mul16.sv
// Sequential shift-add multiplier with signed/unsigned operands and N+1 cycle latency.
// Define SEQ_MUL_RADIX4_EN to retire two multiplier bits per cycle (N = WIDTH/2 instead of WIDTH).
module seq_mul16 #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iStart,
   input  logic             iSigned,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oResultL,
   output logic [WIDTH-1:0] oResultH
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

`ifdef SEQ_MUL_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int N_ITER = WIDTH / STEP;
   localparam int CW     = $clog2(WIDTH + 1);

   logic [1:0]         r_state;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_neg;
   logic               r_done;
   logic [WIDTH-1:0]   r_resl;
   logic [WIDTH-1:0]   r_resh;

   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [2*WIDTH-1:0] w_pp;
   logic [2*WIDTH-1:0] w_prod;

   // The most negative operand negates to itself, which read unsigned is exactly 2^(WIDTH-1).
   always_comb begin
      w_mag_a = (iSigned && iA[WIDTH-1]) ? (~iA + 1'b1) : iA;
      w_mag_b = (iSigned && iB[WIDTH-1]) ? (~iB + 1'b1) : iB;
`ifdef SEQ_MUL_RADIX4_EN
      case (r_mplier[1:0])
         2'd1:    w_pp = r_mcand;
         2'd2:    w_pp = r_mcand << 1;
         2'd3:    w_pp = r_mcand + (r_mcand << 1);
         default: w_pp = '0;
      endcase
`else
      w_pp = r_mplier[0] ? r_mcand : '0;
`endif
      w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_done   <= 1'b0;
         r_resl   <= '0;
         r_resh   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (iStart) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier <= w_mag_b;
                  r_neg    <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                  r_acc    <= '0;
                  r_cnt    <= CW'(N_ITER);
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc    <= r_acc + w_pp;
               r_mplier <= r_mplier >> STEP;
               r_mcand  <= r_mcand << STEP;
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == CW'(1))
                  r_state <= S_FIX;
            end
            S_FIX: begin
               {r_resh, r_resl} <= w_prod;
               r_done           <= 1'b1;
               r_state          <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign oBusy    = (r_state == S_RUN) || (r_state == S_FIX);
   assign oDone    = r_done;
   assign oResultL = r_resl;
   assign oResultH = r_resh;

endmodule

// File: tb/tb_seq_mul16.sv
// Bench for seq_mul16: directed corner table, handshake sequences and random products vs. an arithmetic model.
module tb_seq_mul16;

   logic        Clock;
   logic        Reset;
   logic        iStart;
   logic        iSigned;
   logic [15:0] iA;
   logic [15:0] iB;
   logic        oBusy;
   logic        oDone;
   logic [15:0] oResultL;
   logic [15:0] oResultH;

`ifdef SEQ_MUL_RADIX4_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 17;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[7];

   seq_mul16 #(.WIDTH(16)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .iStart   (iStart),
      .iSigned  (iSigned),
      .iA       (iA),
      .iB       (iB),
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oResultL (oResultL),
      .oResultH (oResultH)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
      longint p;
      if (s)
         p = longint'(shortint'(a)) * longint'(shortint'(b));
      else
         p = longint'({16'b0, a}) * longint'({16'b0, b});
      return p[31:0];
   endfunction

   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
      iA      = a;
      iB      = b;
      iSigned = s;
      iStart  = 1'b1;
      tick();
      iStart  = 1'b0;
      iA      = 16'($urandom);
      iB      = 16'($urandom);
      iSigned = 1'($urandom);
   endtask

   // Returns cycles from the start edge to oDone and whether the outputs stayed put meanwhile.
   task automatic wait_done(output int cyc, output logic held);
      logic [31:0] r0;
      r0   = {oResultH, oResultL};
      cyc  = 0;
      held = 1'b1;
      do begin
         tick();
         cyc++;
         if (!oDone && ({oResultH, oResultL} !== r0))
            held = 1'b0;
      end while (!oDone && cyc < 200);
   endtask

   initial begin
      int          cyc;
      int          c;
      int          ndone;
      int          done_cyc;
      logic        held;
      logic [31:0] res;
      logic [31:0] exp;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;

      vt[0] = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1};
      vt[1] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
      vt[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
      vt[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
      vt[4] = '{16'h1234, 16'h0000, 1'b0, 32'h0000_0000};
      vt[5] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000};
      vt[6] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000};

      Reset   = 1'b1;
      iStart  = 1'b0;
      iSigned = 1'b0;
      iA      = '0;
      iB      = '0;
      tick();
      tick();
      check("reset_busy", 32'(oBusy), 32'd0);
      check("reset_done", 32'(oDone), 32'd0);
      check("reset_resl", 32'(oResultL), 32'd0);
      check("reset_resh", 32'(oResultH), 32'd0);
      Reset = 1'b0;
      tick();

      foreach (vt[i]) begin
         start_op(vt[i].a, vt[i].b, vt[i].s);
         check("tbl_busy", 32'(oBusy), 32'd1);
         wait_done(cyc, held);
         check("tbl_latency", cyc, LAT);
         check("tbl_result", {oResultH, oResultL}, vt[i].exp);
         check("tbl_hold", 32'(held), 32'd1);
         tick();
         check("tbl_done_pulse", 32'(oDone), 32'd0);
         check("tbl_idle", 32'(oBusy), 32'd0);
         check("tbl_result_kept", {oResultH, oResultL}, vt[i].exp);
      end

      // A second start pulsed mid-run must be ignored entirely.
      start_op(16'd7, 16'd9, 1'b0);
      c = 0;
      repeat (4) begin
         tick();
         c++;
      end
      iA = 16'd2;
      iB = 16'd2;
      iStart = 1'b1;
      tick();
      c++;
      iStart = 1'b0;
      ndone = 0;
      done_cyc = 0;
      res = '0;
      while (c < LAT + 8) begin
         if (oDone) begin
            ndone++;
            done_cyc = c;
            res = {oResultH, oResultL};
         end
         tick();
         c++;
      end
      check("busy_start_ndone", ndone, 1);
      check("busy_start_latency", done_cyc, LAT);
      check("busy_start_result", res, 32'h0000_003F);

      // Back-to-back: new start issued in the oDone cycle.
      start_op(16'd5, 16'd6, 1'b0);
      wait_done(cyc, held);
      check("b2b_first", {oResultH, oResultL}, 32'd30);
      start_op(16'd100, 16'hFFFF, 1'b1);
      check("b2b_accepted", 32'(oBusy), 32'd1);
      check("b2b_first_held", {oResultH, oResultL}, 32'd30);
      wait_done(cyc, held);
      check("b2b_latency", cyc, LAT);
      check("b2b_second", {oResultH, oResultL}, 32'hFFFF_FF9C);
      check("b2b_hold", 32'(held), 32'd1);

      // Reset mid-run aborts; result registers clear.
      start_op(16'h1234, 16'h5678, 1'b0);
      repeat (4) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("abort_busy", 32'(oBusy), 32'd0);
      check("abort_result", {oResultH, oResultL}, 32'd0);
      ndone = 0;
      repeat (LAT + 3) begin
         if (oDone) ndone++;
         tick();
      end
      check("abort_no_done", ndone, 0);
      start_op(16'h1234, 16'h5678, 1'b0);
      wait_done(cyc, held);
      check("abort_restart_latency", cyc, LAT);
      check("abort_restart_result", {oResultH, oResultL}, ref_mul(16'h1234, 16'h5678, 1'b0));

      // Reset wins over a simultaneous start.
      tick();
      Reset  = 1'b1;
      iStart = 1'b1;
      iA     = 16'd3;
      iB     = 16'd3;
      tick();
      Reset  = 1'b0;
      iStart = 1'b0;
      check("reset_prio_busy", 32'(oBusy), 32'd0);
      check("reset_prio_result", {oResultH, oResultL}, 32'd0);

      for (int k = 0; k < 2000; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         case ($urandom_range(0, 7))
            0: ra = 16'h8000;
            1: rb = 16'hFFFF;
            2: ra = 16'h0000;
            default: ;
         endcase
         exp = ref_mul(ra, rb, rs);
         start_op(ra, rb, rs);
         wait_done(cyc, held);
         check("rand_latency", cyc, LAT);
         check("rand_result", {oResultH, oResultL}, exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
